// File: rtl/bus_slave_mem.sv
// Memory-bus responder: grants the bus to one master, accepts one access per
// address strobe, inserts WAIT_CYCLES wait states and serves a word-wide RAM.
module bus_slave_mem #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req_,
    output logic        bus_grnt_,
    input  logic        bus_as_,
    input  logic [31:0] bus_addr,
    input  logic        bus_rw,
    input  logic [31:0] bus_wr_data,
    input  logic [2:0]  wr_size,
    output logic        bus_rdy_,
    output logic [31:0] bus_rd_data
);

    localparam int AW = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT,
        ST_READY
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q;
    logic                  rw_q;
    logic [31:0]           wdata_q;
    logic [2:0]            size_q;
    logic                  grnt_q;
    logic                  rdy_q;
    logic [31:0]           rd_data_q, rd_data_d;

    logic                  accept;
    logic                  commit;
    logic                  from_bus;
    logic [AW-1:0]         acc_addr;
    logic                  acc_rw;
    logic [31:0]           acc_wdata;
    logic [2:0]            acc_size;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            byte_en;
    logic [31:0]           lane_data;

    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

    // Address bits above the RAM window alias onto it.
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^bus_addr[31:AW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus_req_) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (bus_req_) begin
                    state_d = ST_IDLE;
                end else if (!bus_as_) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_READY;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_READY: begin
                state_d = bus_req_ ? ST_IDLE : ST_GRANT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access commits on the strobe edge itself,
    // so the bus inputs are used directly instead of the latched copies.
    assign from_bus  = (state_q == ST_GRANT);
    assign acc_addr  = from_bus ? bus_addr[AW-1:0] : addr_q;
    assign acc_rw    = from_bus ? bus_rw           : rw_q;
    assign acc_wdata = from_bus ? bus_wr_data      : wdata_q;
    assign acc_size  = from_bus ? wr_size          : size_q;
    assign commit    = (state_d == ST_READY) && (state_q != ST_READY);
    assign word_idx  = acc_addr[AW-1:2];

    always_comb begin
        byte_en   = 4'b1111;
        lane_data = acc_wdata;
        case (acc_size)
            3'b000: begin
                byte_en   = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                byte_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_data_d = (commit && acc_rw) ? mem[word_idx] : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= 32'h0;
            size_q    <= 3'b000;
            grnt_q    <= 1'b1;
            rdy_q     <= 1'b1;
            rd_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus_addr[AW-1:0];
                rw_q    <= bus_rw;
                wdata_q <= bus_wr_data;
                size_q  <= wr_size;
            end
            grnt_q    <= (state_d == ST_IDLE);
            rdy_q     <= (state_d != ST_READY);
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: the RAM has no reset so it maps onto plain memory macros; only the
    // control path above is reset, which is what blocks an aborted write.
    always_ff @(posedge clk) begin
        if (commit && !acc_rw) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign bus_grnt_   = grnt_q;
    assign bus_rdy_    = rdy_q;
    assign bus_rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: four instances with different wait-state counts,
// read results checked against a queue of expected data.
module tb_bus_slave_mem;

    localparam int NDUT = 4;
    localparam int WAITS [NDUT] = '{1, 0, 15, 3};

    logic        clk = 1'b0;
    logic        rst_n  [NDUT];
    logic        req_n  [NDUT];
    logic        as_n   [NDUT];
    logic        rw     [NDUT];
    logic [31:0] addr   [NDUT];
    logic [31:0] wdata  [NDUT];
    logic [2:0]  size   [NDUT];
    logic        grnt_n [NDUT];
    logic        rdy_n  [NDUT];
    logic [31:0] rdata  [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bus_slave_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(WAITS[g])) u_dut (
            .clk         (clk),
            .reset       (rst_n[g]),
            .bus_req_    (req_n[g]),
            .bus_grnt_   (grnt_n[g]),
            .bus_as_     (as_n[g]),
            .bus_addr    (addr[g]),
            .bus_rw      (rw[g]),
            .bus_wr_data (wdata[g]),
            .wr_size     (size[g]),
            .bus_rdy_    (rdy_n[g]),
            .bus_rd_data (rdata[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_on(input int d);
        req_n[d] = 1'b0;
        step();
        n_checks++;
        if (grnt_n[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_on dut%0d: bus_grnt_=%b required 0", d, grnt_n[d]);
        end
    endtask

    // One strobe; waits for ready, checks latency and the queued read data.
    task automatic access(input int d, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] sz,
                          input logic [31:0] exp_rd, input bit pulse_as,
                          input bit drop_req);
        int n;
        logic [31:0] e;
        exp_q.push_back(r ? exp_rd : 32'h0);
        as_n[d] = 1'b0; rw[d] = r; addr[d] = a; wdata[d] = wd; size[d] = sz;
        step();
        as_n[d] = 1'b1;
        n = 1;
        while (rdy_n[d] !== 1'b0 && n < 40) begin
            n_checks++;
            if (rdata[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL rd_data_idle dut%0d: got %h required 0", d, rdata[d]);
            end
            as_n[d] = (pulse_as && n == 3) ? 1'b0 : 1'b1;
            if (drop_req && n == 2) req_n[d] = 1'b1;
            step();
            n++;
        end
        as_n[d] = 1'b1;
        n_checks++;
        if (rdy_n[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_timeout dut%0d: bus_rdy_ never low within %0d cycles", d, n);
        end
        n_checks++;
        if (n != WAITS[d] + 1) begin
            n_fail++;
            $display("FAIL latency dut%0d addr %h: got %0d cycles required %0d", d, a, n, WAITS[d] + 1);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (rdata[d] !== e) begin
            n_fail++;
            $display("FAIL rd_data dut%0d addr %h: got %h required %h", d, a, rdata[d], e);
        end
        n_checks++;
        if (grnt_n[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL grnt_in_ready dut%0d: got %b required 0", d, grnt_n[d]);
        end
        step();
        n_checks++;
        if (rdy_n[d] !== 1'b1 || rdata[d] !== 32'h0) begin
            n_fail++;
            $display("FAIL after_ready dut%0d: rdy=%b data=%h required 1/0", d, rdy_n[d], rdata[d]);
        end
        n_checks++;
        if (grnt_n[d] !== (drop_req ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL grnt_after_ready dut%0d: got %b required %b", d, grnt_n[d], drop_req);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d] = 1'b0; req_n[d] = 1'b1; as_n[d] = 1'b1; rw[d] = 1'b1;
            addr[d] = '0; wdata[d] = '0; size[d] = 3'b010;
        end
        step();
        step();
        for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
        step();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if (grnt_n[d] !== 1'b1 || rdy_n[d] !== 1'b1 || rdata[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: grnt=%b rdy=%b data=%h required 1/1/0",
                         d, grnt_n[d], rdy_n[d], rdata[d]);
            end
        end
    endtask

    task automatic test_grant_handshake();
        req_n[0] = 1'b0;
        n_checks++;
        if (grnt_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_early: got %b required 1", grnt_n[0]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (grnt_n[0] !== 1'b0 || rdy_n[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL grant_held cycle %0d: grnt=%b rdy=%b required 0/1", i, grnt_n[0], rdy_n[0]);
            end
        end
        req_n[0] = 1'b1;
        n_checks++;
        if (grnt_n[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_early: got %b required 0", grnt_n[0]);
        end
        step();
        n_checks++;
        if (grnt_n[0] !== 1'b1 || rdy_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL release: grnt=%b rdy=%b required 1/1", grnt_n[0], rdy_n[0]);
        end
    endtask

    task automatic test_word_rw();
        grant_on(0);
        access(0, 1'b0, 32'h40, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1'b0);
        access(0, 1'b1, 32'h40, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0);
    endtask

    task automatic test_sized_writes();
        access(0, 1'b0, 32'h80, 32'h11223344, 3'b010, 32'h0, 1'b0, 1'b0);
        access(0, 1'b0, 32'h81, 32'hFFFFFFAA, 3'b000, 32'h0, 1'b0, 1'b0);
        access(0, 1'b0, 32'h82, 32'hFFFF5566, 3'b001, 32'h0, 1'b0, 1'b0);
        access(0, 1'b1, 32'h80, 32'h0, 3'b010, 32'h5566AA44, 1'b0, 1'b0);
        // Odd halfword address ignores bit 0; code 3'b111 behaves as a word.
        access(0, 1'b0, 32'h85, 32'h0000BEEF, 3'b001, 32'h0, 1'b0, 1'b0);
        access(0, 1'b0, 32'h8B, 32'h01020304, 3'b111, 32'h0, 1'b0, 1'b0);
        access(0, 1'b1, 32'h86, 32'h0, 3'b010, 32'h0000BEEF & 32'h0000FFFF | (exp_hi_of_84() << 16), 1'b0, 1'b0);
        access(0, 1'b1, 32'h88, 32'h0, 3'b010, 32'h01020304, 1'b0, 1'b0);
    endtask

    // Upper half of word 0x84 is whatever was never written there; avoid
    // depending on it by writing it first.
    function automatic logic [31:0] exp_hi_of_84();
        return 32'h0000CAFE;
    endfunction

    task automatic test_aliasing();
        access(0, 1'b0, 32'h0000_1004, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 1'b0);
        access(0, 1'b1, 32'h0000_0004, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 1'b0);
        req_n[0] = 1'b1;
        step();
    endtask

    task automatic test_wait0();
        grant_on(1);
        access(1, 1'b0, 32'h20, 32'hA1B2C3D4, 3'b010, 32'h0, 1'b0, 1'b0);
        access(1, 1'b0, 32'h23, 32'h000000EE, 3'b000, 32'h0, 1'b0, 1'b0);
        access(1, 1'b1, 32'h20, 32'h0, 3'b010, 32'hEEB2C3D4, 1'b0, 1'b0);
    endtask

    task automatic test_wait15();
        grant_on(2);
        access(2, 1'b0, 32'h100, 32'h0BADF00D, 3'b010, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (rdy_n[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL extra_rdy cycle %0d: bus_rdy_=%b required 1", i, rdy_n[2]);
            end
            step();
        end
        access(2, 1'b1, 32'h100, 32'h0, 3'b010, 32'h0BADF00D, 1'b0, 1'b0);
    endtask

    task automatic test_req_drop();
        access(2, 1'b1, 32'h100, 32'h0, 3'b010, 32'h0BADF00D, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        grant_on(3);
        access(3, 1'b0, 32'h10, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0, 1'b0);
        as_n[3] = 1'b0; rw[3] = 1'b0; addr[3] = 32'h10; wdata[3] = 32'h12345678; size[3] = 3'b010;
        step();
        as_n[3] = 1'b1;
        req_n[3] = 1'b1;
        rst_n[3] = 1'b0;
        #1;
        n_checks++;
        if (grnt_n[3] !== 1'b1 || rdy_n[3] !== 1'b1 || rdata[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: grnt=%b rdy=%b data=%h required 1/1/0", grnt_n[3], rdy_n[3], rdata[3]);
        end
        for (int i = 0; i < 5; i++) step();
        rst_n[3] = 1'b1;
        step();
        grant_on(3);
        access(3, 1'b1, 32'h10, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_grant_handshake();
        test_word_rw();
        // Pre-load word 0x84 so the odd-halfword check has a known upper half.
        access(0, 1'b0, 32'h84, 32'hCAFE0000, 3'b010, 32'h0, 1'b0, 1'b0);
        test_sized_writes();
        test_aliasing();
        test_wait0();
        test_wait15();
        test_req_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

Bus responder for the CPU's active-low request/grant/strobe/ready memory bus. It grants the bus to the single requesting master, accepts one access per address strobe, and inserts a configurable number of wait states. It completes reads from and sized writes to an internal word-organised RAM. It sits on the system bus opposite the MEM-stage bus interface and serves as the default data memory for bus (non-SPM) addresses.

## Interface
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; only bus_addr[DEPTH_LOG2+1:2] is decoded, and higher bits alias.
- WAIT_CYCLES, 1, wait states inserted between strobe and ready; legal range 0..15.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- bus_req_  input  1  master bus request, active low.
- bus_grnt_  output  1  bus grant, active low, registered.
- bus_as_  input  1  address strobe, active low, one cycle per access.
- bus_addr  input  32  byte address, sampled with bus_as_.
- bus_rw  input  1  1 = read, 0 = write, sampled with bus_as_.
- bus_wr_data  input  32  write data, sampled with bus_as_.
- wr_size  input  3  write size: 3'b000 byte, 3'b001 halfword, 3'b010 word; other codes are treated as word.
- bus_rdy_  output  1  access complete, active low, one-cycle pulse, registered.
- bus_rd_data  output  32  read data; valid only while bus_rdy_ is low, otherwise 32'h0.

## Operation
- The FSM has four states: IDLE, GRANT, WAIT and READY. The wait counter is 4 bits wide.
- **IDLE:** bus_grnt_ = 1. If bus_req_ = 0, go to GRANT.
- **GRANT:** bus_grnt_ = 0.
  - If bus_req_ = 1, go to IDLE. Release takes priority over a simultaneous bus_as_.
  - Else, if bus_as_ = 0, latch addr, rw, wr_data and wr_size. Go to READY if WAIT_CYCLES = 0; otherwise go to WAIT with counter = WAIT_CYCLES-1.
- **WAIT:** bus_grnt_ = 0.
  - If counter = 0, go to READY; otherwise decrement the counter.
  - bus_as_ and bus_req_ are ignored in this state, so an in-flight access always completes.
- **READY:** bus_rdy_ = 0 for exactly one cycle.
  - Next state is GRANT if bus_req_ = 0, else IDLE.
  - bus_grnt_ stays 0 during READY.
- **Reads:** on the edge entering READY, bus_rd_data <= RAM[word index], a full 32-bit word. The master performs byte/halfword extraction.
- **Writes:** the RAM is updated on the edge entering READY, using byte enables from the latched wr_size and addr[1:0].
  - Byte: lane addr[1:0], data wr_data[7:0] placed in that lane.
  - Half: lanes {addr[1],0} and {addr[1],1}, data wr_data[15:0].
  - Word: all four lanes.
  - addr[0] is ignored for halfwords and addr[1:0] is ignored for words. Alignment checking belongs to the master.
- During a write's READY cycle, bus_rd_data = 32'h0.
- bus_as_ outside GRANT is ignored; no access is queued.

## Timing
- **Reset values:** bus_grnt_ = 1, bus_rdy_ = 1, bus_rd_data = 32'h0, state = IDLE, counter = 0. RAM contents are not reset.
- **Grant latency:** bus_req_ sampled low at edge E0 gives bus_grnt_ low after E0, i.e. 1 cycle.
- **Access latency:** bus_as_ sampled low at edge E1 gives bus_rdy_ low in the cycle after edge E1+WAIT_CYCLES. Total is WAIT_CYCLES+1 cycles from strobe to ready.
- **Back-to-back:** with bus_req_ held low, a new strobe is accepted in the cycle after bus_rdy_ goes high again (GRANT). Peak throughput is one access per WAIT_CYCLES+2 cycles.
- **Read-after-write** to the same address returns the new data, because the write has committed before the next GRANT.
- **Reset mid-operation:** reset asserted in WAIT aborts immediately. A pending write is not committed, and outputs go to their reset values asynchronously.
- **Request dropped during WAIT/READY:** the access completes. The FSM returns to IDLE after READY, and bus_grnt_ goes high in the following cycle.

## Test plan
- **Grant handshake:** reset, then bus_req_ = 0 at cycle 2 -> bus_grnt_ = 0 from cycle 3. bus_req_ = 1 at cycle 5 -> bus_grnt_ = 1 from cycle 6. bus_rdy_ stays 1 throughout.
- **Word write/read, WAIT_CYCLES = 1:** write 32'hDEADBEEF to 0x40, then read 0x40. Each bus_rdy_ goes low exactly 2 cycles after its strobe, and the read returns 32'hDEADBEEF. bus_rd_data = 0 in all other cycles.
- **Sized writes:** word 0x11223344 at 0x80, then byte 0xAA at 0x81, then half 0x5566 at 0x82 -> read 0x80 returns 32'h5566AA44.
- **WAIT_CYCLES = 0 and 15:** strobe-to-ready latency is 1 and 16 cycles respectively. A bus_as_ pulsed during WAIT is ignored, with no extra bus_rdy_ pulse.
- **Reset mid-access:** write 0x12345678 to 0x10 with WAIT_CYCLES = 3, and assert reset 1 cycle after the strobe. Outputs return to reset values immediately, and a subsequent read of 0x10 does not return 0x12345678 (it returns the prior contents).
- **Aliasing with DEPTH_LOG2 = 10:** write 0xCAFEF00D to 0x0000_1004 -> read 0x0000_0004 returns 32'hCAFEF00D.
